// File: rtl/dff_share_pkg.sv
// rtl/dff_share_pkg.sv - shared types and helpers for the dff_share_arbiter slice
package dff_share_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin successor of cur among n slots, wrapping n-1 back to 0.
  function automatic logic [31:0] rr_next(input logic [31:0] cur, input logic [31:0] n);
    return (cur >= n - 32'd1) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/dff_share_arbiter_rr_pick.sv
// rtl/dff_share_arbiter_rr_pick.sv - rotate-priority selector starting at ptr
module rr_pick
  import dff_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] sel,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    sel  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + 32'(k)) % 32'(N_REQ));
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        sel[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_share_arbiter_sva.sv
// rtl/dff_share_arbiter_sva.sv - protocol checker bound into dff_share_arbiter
module dff_share_arbiter_sva #(
  parameter int N_REQ = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic [N_REQ-1:0] gnt,
  input logic             busy,
  input logic             q_valid
);

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

  a_gnt_busy: assert property (@(posedge clk) disable iff (!rst_n) (|gnt) |-> busy);

  a_qv_busy: assert property (@(posedge clk) disable iff (!rst_n) q_valid |-> $past(busy));

  // Ownership never hands over directly: a grant can only change through all-zero.
  a_gap: assert property (@(posedge clk) disable iff (!rst_n)
                          ((|gnt) && $past(|gnt)) |-> (gnt == $past(gnt)));

endmodule

// File: rtl/dff_share_arbiter.sv
// rtl/dff_share_arbiter.sv - round-robin owner of one shared capture register
module dff_share_arbiter
  import dff_share_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data_in,
  output logic [N_REQ-1:0]          gnt,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      busy,
  output logic [DATA_W-1:0]         q,
  output logic                      q_valid
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [N_REQ-1:0] pick_sel;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [DATA_W-1:0] own_data;
  logic             own_req;
  logic             last_load;
  logic             release_own;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req (req),
    .ptr (ptr),
    .sel (pick_sel),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign own_data    = data_in[32'(owner)*DATA_W +: DATA_W];
  assign own_req     = req[owner];
  assign last_load   = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign release_own = (state == OWN) && (!own_req || last_load);
  assign busy        = (state == OWN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (pick_any) state_nx = OWN;
      OWN:  if (release_own) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt      <= pick_sel;
            owner    <= pick_idx;
            hold_cnt <= '0;
          end
        end
        OWN: begin
          if (own_req) begin
            q        <= own_data;
            q_valid  <= 1'b1;
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
          // Clearing hold_cnt on release keeps it within 0..MAX_HOLD-1.
          if (release_own) begin
            gnt      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            ptr      <= IDX_W'(rr_next(32'(owner), 32'(N_REQ)));
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_share_arbiter.sv
// tb/tb_dff_share_arbiter.sv - directed self-checking bench for dff_share_arbiter
module tb_dff_share_arbiter;

  localparam int N_REQ = 4;
  localparam int DATA_W = 8;
  localparam int MAX_HOLD = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data_in;
  logic [N_REQ-1:0]        gnt;
  logic [1:0]              owner;
  logic                    busy;
  logic [DATA_W-1:0]       q;
  logic                    q_valid;

  int n_run  = 0;
  int n_fail = 0;

  dff_share_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .data_in (data_in),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .q       (q),
    .q_valid (q_valid)
  );

  bind dff_share_arbiter dff_share_arbiter_sva #(.N_REQ(N_REQ)) u_sva (
    .clk     (clk),
    .rst_n   (rst_n),
    .gnt     (gnt),
    .busy    (busy),
    .q_valid (q_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DATA_W-1:0] d);
    data_in[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] rr_data [N_REQ];
    rr_data[0] = 8'h10; rr_data[1] = 8'h20; rr_data[2] = 8'h30; rr_data[3] = 8'h40;

    rst_n = 1'b0; req = '0; data_in = '0;
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_qv", 32'(q_valid), 0);

    // Single requester: grant, 4 loads, gap, re-grant
    rst_n = 1'b1; req = 4'b0001; set_data(0, 8'hA5);
    tick();
    chk("s_gnt", 32'(gnt), 32'b0001);
    chk("s_busy", 32'(busy), 1);
    chk("s_qv0", 32'(q_valid), 0);
    for (int j = 1; j <= MAX_HOLD; j++) begin
      tick();
      chk($sformatf("s_q%0d", j), 32'(q), 32'hA5);
      chk($sformatf("s_qv%0d", j), 32'(q_valid), 1);
      chk($sformatf("s_gnt%0d", j), 32'(gnt), (j < MAX_HOLD) ? 32'b0001 : 32'b0000);
    end
    tick();
    chk("s_regnt", 32'(gnt), 32'b0001);
    chk("s_regnt_qv", 32'(q_valid), 0);
    req = 4'b0000;
    tick();
    chk("s_drop_gnt", 32'(gnt), 0);
    chk("s_drop_qv", 32'(q_valid), 0);

    // Round-robin with all four requesting
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N_REQ; i++) set_data(i, rr_data[i]);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(1) << (k % 4));
      chk($sformatf("rr%0d_owner", k), 32'(owner), 32'(k % 4));
      chk($sformatf("rr%0d_qv", k), 32'(q_valid), 0);
      if (k < 4) begin
        for (int j = 1; j <= MAX_HOLD; j++) begin
          tick();
          chk($sformatf("rr%0d_q%0d", k, j), 32'(q), 32'(rr_data[k]));
          chk($sformatf("rr%0d_qv%0d", k, j), 32'(q_valid), 1);
          chk($sformatf("rr%0d_g%0d", k, j), 32'(gnt),
              (j < MAX_HOLD) ? (32'(1) << k) : 32'd0);
        end
      end
    end
    req = 4'b0000;
    tick();
    chk("rr_end_gnt", 32'(gnt), 0);

    // Early release of owner 2 after two loads; ptr is 1 here
    req = 4'b0100; set_data(2, 8'h77);
    tick();
    chk("er_gnt", 32'(gnt), 32'b0100);
    chk("er_owner", 32'(owner), 2);
    tick();
    chk("er_q1", 32'(q), 32'h77);
    set_data(2, 8'h78);
    tick();
    chk("er_q2", 32'(q), 32'h78);
    chk("er_qv2", 32'(q_valid), 1);
    req = 4'b1001;
    tick();
    chk("er_rel_gnt", 32'(gnt), 0);
    chk("er_rel_qv", 32'(q_valid), 0);
    chk("er_rel_q", 32'(q), 32'h78);
    chk("er_rel_busy", 32'(busy), 0);
    tick();
    chk("er_next_owner", 32'(owner), 3);
    chk("er_next_gnt", 32'(gnt), 32'b1000);

    // Wrap-around: leave ptr at 3, then req=0011 scans 3 -> 0
    do_reset();
    req = 4'b0100;
    tick();
    chk("wr_gnt2", 32'(gnt), 32'b0100);
    req = 4'b0011; set_data(0, 8'h01); set_data(1, 8'h02);
    tick();
    chk("wr_rel", 32'(gnt), 0);
    tick();
    chk("wr_owner0", 32'(owner), 0);
    chk("wr_gnt0", 32'(gnt), 32'b0001);
    for (int j = 1; j <= MAX_HOLD; j++) begin
      tick();
      chk($sformatf("wr_q%0d", j), 32'(q), 32'h01);
    end
    chk("wr_gap", 32'(gnt), 0);
    tick();
    chk("wr_owner1", 32'(owner), 1);
    chk("wr_gnt1", 32'(gnt), 32'b0010);

    // Asynchronous reset while owning with q=55
    set_data(1, 8'h55);
    tick();
    chk("ar_q", 32'(q), 32'h55);
    chk("ar_qv", 32'(q_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 0);
    chk("ar_q0", 32'(q), 0);
    chk("ar_qv0", 32'(q_valid), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_owner", 32'(owner), 0);
    req = 4'b0100;
    #3;
    rst_n = 1'b1;
    tick();
    chk("ar_after_owner", 32'(owner), 2);
    chk("ar_after_gnt", 32'(gnt), 32'b0100);

    // Idle stability
    req = 4'b0000;
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("id%0d_gnt", c), 32'(gnt), 0);
      chk($sformatf("id%0d_busy", c), 32'(busy), 0);
      chk($sformatf("id%0d_qv", c), 32'(q_valid), 0);
      chk($sformatf("id%0d_q", c), 32'(q), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dff_share_arbiter.md
Name: dff_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one DATA_W-bit capture register (a bank of D flip-flops) between N_REQ requesters.
- Grants one requester at a time, loads that requester's data into the shared register on each granted cycle, and bounds ownership to MAX_HOLD loads.
- Sits between requesting producers and the shared register; the register value and a valid strobe go to downstream consumers.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- DATA_W, 8, width of the shared register and of each requester's data.
- MAX_HOLD, 4, maximum consecutive loads per grant (≥1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  N_REQ  per-requester level request.
- data_in  input  N_REQ*DATA_W  packed requester data; slice i = data_in[i*DATA_W +: DATA_W].
- gnt  output  N_REQ  registered one-hot grant, or all-zero.
- owner  output  $clog2(N_REQ)  index of the current grantee; 0 when idle.
- busy  output  1  high while the FSM is in OWN.
- q  output  DATA_W  shared register contents.
- q_valid  output  1  one-cycle pulse: q was loaded at the last edge.

Behaviour:
- Reset (rst_n low, asynchronous, also mid-operation): state=IDLE, gnt=0, owner=0, busy=0, q=0, q_valid=0, rr pointer ptr=0, hold_cnt=0. Operation resumes at the first edge after rst_n rises.
- FSM has two states, IDLE and OWN.
- IDLE:
  - gnt=0.
  - At an edge, if any req bit is high: select the first i with req[i]=1, scanning ptr, ptr+1, … mod N_REQ.
  - Then gnt<=onehot(i), owner<=i, hold_cnt<=0, state<=OWN.
  - If no req bit is high, stay in IDLE.
  - q_valid<=0 on every IDLE edge.
- OWN, with grantee g:
  - If req[g]=1: q<=data_in[g], q_valid<=1, hold_cnt<=hold_cnt+1.
    - If hold_cnt==MAX_HOLD-1, this is the last load: release.
  - If req[g]=0: no load, q_valid<=0, release.
- Release: gnt<=0, state<=IDLE, ptr<=(g+1) mod N_REQ, owner<=0.
  - q holds its value.
  - The mandatory one-cycle IDLE gap between owners is intentional.
- Latency:
  - req[i] high at edge t (FSM in IDLE) → gnt[i] high after t → first load at edge t+1 → q and q_valid visible after t+1.
  - Single-requester sustained throughput: MAX_HOLD loads per MAX_HOLD+1 cycles.
- Fairness:
  - ptr only advances past the released owner, so a requester forced out by MAX_HOLD is eligible again only after every other requester that is asserting req has been scanned.
  - A sole requester is re-granted immediately after the gap.
- Simultaneous events:
  - Multiple reqs in IDLE → the ptr-ordered winner; all others wait.
  - req[g] dropping on the edge where hold_cnt would expire → no-load release; ptr advances identically.
  - Changes on non-owner req bits while in OWN are ignored.
- Invariants:
  - gnt is one-hot or zero (onehot0).
  - q changes only on edges where q_valid goes high.
  - hold_cnt never exceeds MAX_HOLD-1 when observed.
  - hold_cnt width is $clog2(MAX_HOLD+1).
  - ptr wraps from N_REQ-1 to 0.

Decomposition:
- Package dff_share_pkg holds:
  - the state enum (IDLE, OWN);
  - the localparam width helper for ptr/owner;
  - a rr_next function (ptr+1 wrap).
- One natural sub-module, rr_pick:
  - combinational rotate-priority selector taking req and ptr, producing a one-hot select and its index;
  - instantiated once.
- Concurrent assertions in a separate bound checker module, sampled on posedge clk with disable iff (!rst_n). They check:
  - onehot0(gnt);
  - gnt |-> busy;
  - q_valid |-> $past(busy);
  - the gap after release.

Test Plan (defaults N_REQ=4, DATA_W=8, MAX_HOLD=4):
- Single requester: req=4'b0001 held, data_in[0]=8'hA5 → gnt=0001 one cycle after req, then 4 q_valid pulses with q=A5, one gnt=0 gap, then re-grant to 0.
- Round-robin: req=4'b1111 held, distinct data 8'h10/8'h20/8'h30/8'h40 → grant order 0,1,2,3,0; each owner gets exactly 4 loads; gnt is all-zero for 1 cycle between owners.
- Early release: grant 2, drop req[2] after 2 loads → exactly 2 q_valid pulses, q=last data; next arbitration scans from index 3 (req=1001 → owner 3).
- Wrap-around: ptr=3, req=4'b0011 → owner 0 (scan 3→0); then owner 1.
- Reset mid-operation: assert rst_n=0 between edges while owning with q=8'h55 → gnt, q, q_valid, busy go 0 immediately (no clock); after release, req=0100 → owner 2 (ptr restarted at 0).
- Idle stability: req=0 for 10 cycles → gnt=0, busy=0, q_valid=0, q unchanged; no assertion fires.
